// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full / almost-empty thresholds and a registered read port.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// flags cleared by err_clr; without it both outputs are tied low.
module sync_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        rd,
  output logic [DATA_W-1:0]           data_out,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(DEPTH):0]      count,
  input  logic                        err_clr,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int ADDR_W = $clog2(DEPTH);

  // Thresholds narrowed to the count width so comparisons are width-matched.
  localparam logic [ADDR_W:0] AFULL_CNT  = AFULL_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_CNT = AEMPTY_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  // Storage: no reset, contents are undefined until written.
  logic [DATA_W-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit to distinguish full from empty.
  logic [ADDR_W:0]   wrptr_q, wrptr_d;
  logic [ADDR_W:0]   rdptr_q, rdptr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic              empty_w;
  logic              full_w;
  logic [ADDR_W:0]   count_w;
  logic              wr_ok;
  logic              rd_ok;

  // Status decode from registered pointers only (no path from wr/rd/data_in).
  always_comb begin
    count_w = wrptr_q - rdptr_q;
    empty_w = (wrptr_q == rdptr_q);
    full_w  = (wrptr_q[ADDR_W] != rdptr_q[ADDR_W]) &&
              (wrptr_q[ADDR_W-1:0] == rdptr_q[ADDR_W-1:0]);
  end

  assign count        = count_w;
  assign empty        = empty_w;
  assign full         = full_w;
  assign almost_full  = (count_w >= AFULL_CNT);
  assign almost_empty = (count_w <= AEMPTY_CNT);
  assign data_out     = data_out_q;

  // Request acceptance and next-state for pointers and the read register.
  // Write and read are judged independently against the current flags, so a
  // read from empty is never satisfied by a same-cycle write (no bypass).
  always_comb begin
    wr_ok      = wr & ~full_w;
    rd_ok      = rd & ~empty_w;
    wrptr_d    = wrptr_q;
    rdptr_d    = rdptr_q;
    data_out_d = data_out_q;
    if (wr_ok) begin
      wrptr_d = wrptr_q + PTR_ONE;
    end
    if (rd_ok) begin
      rdptr_d    = rdptr_q + PTR_ONE;
      data_out_d = mem[rdptr_q[ADDR_W-1:0]];
    end
  end

  // Pointer and read-data registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrptr_q    <= '0;
      rdptr_q    <= '0;
      data_out_q <= '0;
    end else begin
      wrptr_q    <= wrptr_d;
      rdptr_q    <= rdptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Memory write port; entries are left in place after being read.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wrptr_q[ADDR_W-1:0]] <= data_in;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error next-state: a new error in the same cycle beats err_clr.
  always_comb begin
    overflow_d  = (wr & full_w)  | (overflow_q  & ~err_clr);
    underflow_d = (rd & empty_w) | (underflow_q & ~err_clr);
  end

  // Sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  // Error flags disabled: outputs tied low and err_clr has no effect.
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed plus random stimulus against a queue-based
// reference model of the FIFO (DATA_W=8, DEPTH=8, AFULL_LVL=6, AEMPTY_LVL=2).
module tb_sync_fifo_param;

  localparam int DATA_W     = 8;
  localparam int DEPTH      = 8;
  localparam int AFULL_LVL  = 6;
  localparam int AEMPTY_LVL = 2;
  localparam int ADDR_W     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              err_clr;
  logic              overflow;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_dout;
  bit                exp_ovf;
  bit                exp_unf;

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL), .AEMPTY_LVL(AEMPTY_LVL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int unsigned obs, input int unsigned expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".data_out"},     data_out,     exp_dout);
    check({tag, ".count"},        count,        n);
    check({tag, ".empty"},        empty,        (n == 0));
    check({tag, ".full"},         full,         (n == DEPTH));
    check({tag, ".almost_full"},  almost_full,  (n >= AFULL_LVL));
    check({tag, ".almost_empty"}, almost_empty, (n <= AEMPTY_LVL));
    check({tag, ".overflow"},     overflow,     exp_ovf);
    check({tag, ".underflow"},    underflow,    exp_unf);
    $display("%s: wr=%0b rd=%0b count=%0d data_out=0x%02h ovf=%0b unf=%0b",
             tag, wr, rd, count, data_out, overflow, underflow);
  endtask

  // One clock of stimulus: drive, advance model at the edge, check after it.
  task automatic step(input bit w, input bit r, input logic [DATA_W-1:0] d,
                      input bit c, input string tag);
    bit was_full;
    bit was_empty;
    wr = w; rd = r; data_in = d; err_clr = c;
    @(posedge clk);
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    exp_ovf = (w && was_full)  || (exp_ovf && !c);
    exp_unf = (r && was_empty) || (exp_unf && !c);
`endif
    if (r && !was_empty) exp_dout = model_q.pop_front();
    if (w && !was_full)  model_q.push_back(d);
    #1;
    wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; data_in = '0;
    exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
    #2;
    check_all("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Fill 0x01..0x08, then a rejected 9th write
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 8'(i), 1'b0, "fill");
    // Drain 8, then a 9th read from empty
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "drain");

    // Error clear: set overflow, clear together with a new overflow, then clear alone
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, "refill");
    step(1'b1, 1'b0, 8'h5A, 1'b1, "clr_with_set");
    step(1'b0, 1'b0, 8'h00, 1'b1, "clr_alone");
    step(1'b0, 1'b0, 8'h00, 1'b0, "idle");

    // Simultaneous rd & wr at count 4
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "to4");
    step(1'b1, 1'b1, 8'h77, 1'b0, "rdwr_cnt4");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, "to_full");
    step(1'b1, 1'b1, 8'hEE, 1'b0, "rdwr_full");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00, 1'b0, "to_empty");
    step(1'b1, 1'b1, 8'hC3, 1'b0, "rdwr_empty");
    step(1'b0, 1'b1, 8'h00, 1'b0, "rd_c3");

    // Wrap-around: interleaved single writes and reads, data 0x10..0x23
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, "wrap_wr");
      step(1'b0, 1'b1, 8'h00, 1'b0, "wrap_rd");
    end

    // Async reset mid-stream at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom_range(255)), 1'b0, "pre_rst");
    #3 rst_n = 1'b0;
    #1;
    model_q.delete();
    exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
    check_all("async_rst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1'b1, 1'b0, 8'hAA, 1'b0, "post_rst_wr");
    step(1'b0, 1'b1, 8'h00, 1'b0, "post_rst_rd");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom_range(255)),
           ($urandom_range(7) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
